pc_gen_btb: RTL
===============

Name: pc_gen_btb

Overview:
Parametrised next-generation program counter for the five-stage pipeline fetch stage. Holds curPC and drives a valid/ready fetch request to instruction memory. Selects the next PC by a fixed priority: reset, exception vector, execute-stage redirect, stall/hold, BTB prediction, sequential. Adds a small direct-mapped branch target buffer, so taken branches learned earlier are predicted without a redirect bubble.

Parameters:
ADDR_W, 32, PC width in bits; bits [1:0] always 0.
RESET_VECTOR, 32'h0000_0000, curPC value after reset.
EXC_VECTOR, 32'h0000_0080, target loaded on ExcValid.
BTB_DEPTH, 16, BTB entries; power of two, 2..256.
INC, 4, sequential increment in bytes.

Ports:
CLK  in  1  clock; all state updates on posedge.
Reset  in  1  synchronous, active-high reset.
Stall  in  1  hazard-unit hold; curPC is kept.
RedirectValid  in  1  execute-stage branch/jump resolved to a PC other than the one fetched.
RedirectTarget  in  ADDR_W  redirect destination; bits [1:0] ignored and forced to 0.
ExcValid  in  1  exception/trap request.
FetchReady  in  1  instruction memory accepts the request this cycle.
BtbUpdValid  in  1  BTB write from the execute stage.
BtbUpdPC  in  ADDR_W  PC of the resolved branch.
BtbUpdTarget  in  ADDR_W  resolved target.
BtbUpdTaken  in  1  1 = install entry; 0 = invalidate entry on tag match.
curPC  out  ADDR_W  current fetch address (registered).
FetchValid  out  1  fetch request valid (registered).
PredTaken  out  1  curPC hit in BTB; travels down the pipe with the instruction.
PredTarget  out  ADDR_W  predicted target when PredTaken = 1; otherwise curPC+INC.

Behaviour:
- States: BOOT, RUN.
- Reset: the cycle it is sampled high, it forces curPC = RESET_VECTOR, FetchValid = 0, state = BOOT, and clears all BTB valid bits. It overrides every other input, including mid-operation. BOOT moves to RUN on the next clock with FetchValid = 1 and curPC unchanged.
- Fetch acceptance: accepted = FetchValid & FetchReady & ~Stall.
- Next-PC priority in RUN, evaluated each posedge (first match wins):
  1. ExcValid: curPC <= EXC_VECTOR.
  2. RedirectValid: curPC <= {RedirectTarget[ADDR_W-1:2], 2'b00}. This applies even when Stall or ~FetchReady is active; the pending request is abandoned.
  3. ~accepted: curPC held.
  4. BTB hit: curPC <= stored target.
  5. Otherwise: curPC <= curPC + INC, modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0x0000_0000.
- FetchValid stays 1 in RUN.
- Request stability: while FetchValid = 1 and not accepted, curPC must not change except through steps 1–2.
- BTB indexing: index = PC[log2(BTB_DEPTH)+1:2]; tag = PC[ADDR_W-1:log2(BTB_DEPTH)+2]. Each entry stores {valid, tag, target}.
- BTB lookup is combinational on curPC. PredTaken = valid & (tag match). PredTarget is valid in the same cycle as curPC.
- BTB update is written at posedge.
  - BtbUpdTaken = 1: overwrite {1, tag, target[ADDR_W-1:2], 00} at the index.
  - BtbUpdTaken = 0: clear valid only if the stored tag matches; otherwise no change.
- Update and lookup at the same index in the same cycle: the lookup sees the old contents; the new entry affects the following cycle only.
- An update while Reset is high is dropped.
- An update concurrent with a redirect is applied.
- The BTB never affects curPC while ~accepted.
- No latency beyond one register stage: an input change at edge N is visible on curPC after edge N.

Test Plan:
- Reset, then release with FetchReady = 1 and no other events -> BOOT cycle shows curPC = 0, FetchValid = 0; then RUN with curPC sequence 0, 4, 8, 12 and FetchValid = 1.
- Stall for 3 cycles at curPC = 0x20, then release; separately, FetchReady = 0 for 2 cycles -> curPC holds 0x20 in both cases, then 0x24.
- RedirectValid with target 0x103 while Stall = 1 -> next curPC = 0x100. Same cycle with ExcValid = 1 -> curPC = 0x80 instead.
- BTB update (PC = 0x40, target = 0x200, taken = 1), then run from 0x3C -> PredTaken = 1 at 0x40 and next curPC = 0x200. Update with taken = 0 invalidates it. Update at aliasing PC 0x80 with taken = 0 leaves the 0x40 entry intact (BTB_DEPTH = 16).
- Update to the index of the current curPC in the same cycle -> PredTaken reflects the old entry this cycle and the new one next cycle. curPC = 0xFFFF_FFFC with a BTB miss -> next curPC = 0x0.
- Reset asserted mid-run with a BTB entry installed -> curPC = 0, FetchValid = 0, all PredTaken = 0 afterwards.

Source files
------------

// File: rtl/pc_gen_btb_if.sv
// Fetch-side bundle for pc_gen_btb: pipeline control inputs, BTB training port,
// and the registered fetch request with its branch prediction.
interface pc_gen_btb_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              Stall;
  logic              RedirectValid;
  logic [ADDR_W-1:0] RedirectTarget;
  logic              ExcValid;
  logic              FetchReady;
  logic              BtbUpdValid;
  logic [ADDR_W-1:0] BtbUpdPC;
  logic [ADDR_W-1:0] BtbUpdTarget;
  logic              BtbUpdTaken;
  logic [ADDR_W-1:0] curPC;
  logic              FetchValid;
  logic              PredTaken;
  logic [ADDR_W-1:0] PredTarget;

  modport master (
    input  Stall, RedirectValid, RedirectTarget, ExcValid, FetchReady,
    input  BtbUpdValid, BtbUpdPC, BtbUpdTarget, BtbUpdTaken,
    output curPC, FetchValid, PredTaken, PredTarget
  );

  modport slave (
    output Stall, RedirectValid, RedirectTarget, ExcValid, FetchReady,
    output BtbUpdValid, BtbUpdPC, BtbUpdTarget, BtbUpdTaken,
    input  curPC, FetchValid, PredTaken, PredTarget
  );
endinterface

// File: rtl/pc_gen_btb.sv
// Fetch-stage program counter with a direct-mapped branch target buffer.
// Next PC priority: reset, exception, redirect, hold, BTB prediction, sequential.
module pc_gen_btb #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned       BTB_DEPTH    = 16,
  parameter int unsigned       INC          = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  pc_gen_btb_if.master  bus
);
  localparam int unsigned IDX_W  = $clog2(BTB_DEPTH);
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned TAG_W  = WORD_W - IDX_W;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            r_state, w_stateNext;
  logic [ADDR_W-1:0] r_curPC, w_pcNext;
  logic              r_fetchValid, w_fetchValidNext;

  logic [BTB_DEPTH-1:0] r_btbValid;
  logic [TAG_W-1:0]     r_btbTag    [BTB_DEPTH];
  logic [WORD_W-1:0]    r_btbTarget [BTB_DEPTH];

  logic [WORD_W-1:0] w_curWord, w_updWord, w_updTargetWord, w_redirectWord;
  logic [IDX_W-1:0]  w_curIdx, w_updIdx;
  logic [TAG_W-1:0]  w_curTag, w_updTag;
  logic              w_hit, w_accepted, w_updTagMatch;
  logic [ADDR_W-1:0] w_seqPC, w_predTarget;

  // Word addresses: the byte-offset bits are dropped everywhere.
  assign w_curWord       = WORD_W'(r_curPC >> 2);
  assign w_updWord       = WORD_W'(bus.BtbUpdPC >> 2);
  assign w_updTargetWord = WORD_W'(bus.BtbUpdTarget >> 2);
  assign w_redirectWord  = WORD_W'(bus.RedirectTarget >> 2);

  assign w_curIdx = w_curWord[IDX_W-1:0];
  assign w_curTag = w_curWord[WORD_W-1:IDX_W];
  assign w_updIdx = w_updWord[IDX_W-1:0];
  assign w_updTag = w_updWord[WORD_W-1:IDX_W];

  assign w_hit         = r_btbValid[w_curIdx] && (r_btbTag[w_curIdx] == w_curTag);
  assign w_updTagMatch = r_btbTag[w_updIdx] == w_updTag;
  assign w_seqPC       = r_curPC + ADDR_W'(INC);
  assign w_predTarget  = w_hit ? {r_btbTarget[w_curIdx], 2'b00} : w_seqPC;
  assign w_accepted    = r_fetchValid & bus.FetchReady & ~bus.Stall;

  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_curPC;
    w_fetchValidNext = r_fetchValid;
    case (r_state)
      BOOT: begin
        w_stateNext      = RUN;
        w_fetchValidNext = 1'b1;
      end
      RUN: begin
        w_fetchValidNext = 1'b1;
        // Redirects win over a stalled request; the pending fetch is abandoned.
        if (bus.ExcValid)
          w_pcNext = EXC_VECTOR;
        else if (bus.RedirectValid)
          w_pcNext = {w_redirectWord, 2'b00};
        else if (w_accepted)
          w_pcNext = w_predTarget;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= BOOT;
      r_curPC      <= RESET_VECTOR;
      r_fetchValid <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_curPC      <= w_pcNext;
      r_fetchValid <= w_fetchValidNext;
    end
  end

  // Writes land at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_btbValid <= '0;
    end else if (bus.BtbUpdValid) begin
      if (bus.BtbUpdTaken)
        r_btbValid[w_updIdx] <= 1'b1;
      else if (w_updTagMatch)
        r_btbValid[w_updIdx] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset && bus.BtbUpdValid && bus.BtbUpdTaken) begin
      r_btbTag[w_updIdx]    <= w_updTag;
      r_btbTarget[w_updIdx] <= w_updTargetWord;
    end
  end

  assign bus.curPC      = r_curPC;
  assign bus.FetchValid = r_fetchValid;
  assign bus.PredTaken  = w_hit;
  assign bus.PredTarget = w_predTarget;
endmodule
